axi_apb_bridge_mslv: RTL and testbench

Parametrised AXI4-Lite to APB bridge, successor to the first-generation single-bus bridge. Single-beat AXI4-Lite writes and reads are accepted into per-direction request FIFOs and arbitrated onto one APB master port. Requests are decoded to NUM_SLAVES one-hot select lines, and AXI responses are generated from pslverr or from address decode errors. Sits between the AXI interconnect and the APB peripheral cluster.

---
 rtl/axi_apb_pkg.sv | 12 +
 rtl/bridge_req_fifo.sv | 39 +++
 rtl/axi_apb_bridge_mslv.sv | 198 +++++++++++++++++++
 tb/tb_axi_apb_bridge_mslv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_apb_pkg.sv
// axi_apb_pkg: response codes, APB FSM states and slave-index sizing shared by the bridge
package axi_apb_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} apb_state_t;
  localparam int SEL_BITS = 4;
  localparam int MAX_SLAVES = 1 << SEL_BITS;
endpackage

// File: rtl/bridge_req_fifo.sv
// bridge_req_fifo: synchronous request FIFO with count-based full/empty flags
module bridge_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign pop_data = mem[rp];
  // pointer and occupancy bookkeeping; a same-cycle pop frees its slot only afterwards
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  // storage array, contents are don't-care until pushed
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_data;
endmodule

// File: rtl/axi_apb_bridge_mslv.sv
// axi_apb_bridge_mslv: AXI4-Lite to multi-slave APB bridge with per-direction request FIFOs
// Optional feature macro: APB_TIMEOUT_EN ends a stalled ACCESS with SLVERR after TIMEOUT_CYCLES
module axi_apb_bridge_mslv
  import axi_apb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SLAVES      = 8,
  parameter int SLAVE_SPAN_BITS = 12,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic                             bvalid,
  input  logic                             bready,
  output logic [1:0]                       bresp,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             arvalid,
  output logic                             arready,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);
  localparam int SW = DATA_WIDTH / 8;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         strb;
  } wreq_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
  } rreq_t;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || NUM_SLAVES < 1 ||
      NUM_SLAVES > MAX_SLAVES || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("axi_apb_bridge_mslv: illegal parameter combination");
  end

  wreq_t wq_in, wq_out;
  rreq_t rq_in, rq_out;
  logic wfull, wempty, rfull, rempty, wpush, rpush, wpop, rpop;
  apb_state_t state;
  logic last_rd, w_elig, r_elig, gnt_rd, g_ok;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [SEL_BITS-1:0] g_idx;
  logic sel_rdy, sel_err, acc_done;
  logic [DATA_WIDTH-1:0] sel_data, acc_data;
  resp_t acc_resp;

  // AW and W are only ever taken together; nothing is accepted while reset is held
  assign wpush = awvalid & wvalid & !wfull & !reset;
  assign rpush = arvalid & !rfull & !reset;
  assign awready = wpush;
  assign wready = wpush;
  assign arready = rpush;
  assign wq_in = {awaddr, wdata, wstrb};
  assign rq_in = rreq_t'(araddr);

  bridge_req_fifo #(.WIDTH($bits(wreq_t)), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk(clk), .reset(reset), .push(wpush), .push_data(wq_in), .pop(wpop),
    .pop_data(wq_out), .full(wfull), .empty(wempty)
  );
  bridge_req_fifo #(.WIDTH($bits(rreq_t)), .DEPTH(FIFO_DEPTH)) u_rfifo (
    .clk(clk), .reset(reset), .push(rpush), .push_data(rq_in), .pop(rpop),
    .pop_data(rq_out), .full(rfull), .empty(rempty)
  );

  // a response register being drained this cycle counts as free so transfers run back to back
  assign w_elig = !wempty & (!bvalid | bready);
  assign r_elig = !rempty & (!rvalid | rready);
  assign gnt_rd = r_elig & (!w_elig | !last_rd);
  assign g_addr = gnt_rd ? rq_out.addr : wq_out.addr;
  assign g_idx = g_addr[SLAVE_SPAN_BITS+3:SLAVE_SPAN_BITS];
  assign g_ok = int'(g_idx) < NUM_SLAVES;
  assign rpop = (state == ST_IDLE) & gnt_rd;
  assign wpop = (state == ST_IDLE) & w_elig & !gnt_rd;

  // route the selected slave's handshake and read data back using the one-hot psel
  always_comb begin
    sel_rdy = 1'b0;
    sel_err = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (psel[i]) begin
        sel_rdy = pready[i];
        sel_err = pslverr[i];
        sel_data = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic expired;
  assign expired = !sel_rdy && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign acc_done = sel_rdy | expired;
  assign acc_resp = (expired | sel_err) ? RESP_SLVERR : RESP_OKAY;
  assign acc_data = expired ? '0 : sel_data;
`else
  assign acc_done = sel_rdy;
  assign acc_resp = sel_err ? RESP_SLVERR : RESP_OKAY;
  assign acc_data = sel_data;
`endif

  // APB sequencer with registered APB outputs and the B/R response registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      last_rd <= 1'b0;
      psel <= '0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
      rvalid <= 1'b0;
      rresp <= RESP_OKAY;
      rdata <= '0;
`ifdef APB_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      case (state)
        ST_IDLE:
          if (w_elig || r_elig) begin
            last_rd <= gnt_rd;
            pwrite <= !gnt_rd;
            if (g_ok) begin
              state <= ST_SETUP;
              psel <= NUM_SLAVES'(1) << g_idx;
              paddr <= g_addr;
              pwdata <= gnt_rd ? '0 : wq_out.data;
              pstrb <= gnt_rd ? '0 : wq_out.strb;
            end else state <= ST_RESP;
          end
        ST_SETUP: begin
          penable <= 1'b1;
          state <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        ST_ACCESS: begin
`ifdef APB_TIMEOUT_EN
          tcnt <= tcnt + 1'b1;
`endif
          if (acc_done) begin
            psel <= '0;
            penable <= 1'b0;
            state <= ST_IDLE;
            if (pwrite) begin
              bvalid <= 1'b1;
              bresp <= acc_resp;
            end else begin
              rvalid <= 1'b1;
              rresp <= acc_resp;
              rdata <= acc_data;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (pwrite) begin
            bvalid <= 1'b1;
            bresp <= RESP_DECERR;
          end else begin
            rvalid <= 1'b1;
            rresp <= RESP_DECERR;
            rdata <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_apb_bridge_mslv.sv
// tb_axi_apb_bridge_mslv: directed vector table plus hand sequences for axi_apb_bridge_mslv
module tb_axi_apb_bridge_mslv;
  logic clk = 1'b0, reset;
  logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata;
  logic [3:0] wstrb, pstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, penable, pwrite;
  logic [1:0] bresp, rresp;
  logic [7:0] psel, pready, pslverr;
  logic [255:0] prdata;
  logic [31:0] sdata [8];
  int cfg_ws = 0;
  logic cfg_err = 1'b0, cfg_stuck = 1'b0;
  int acc_cyc = 0, nwr = 0, ntest = 0, nfail = 0;

  typedef struct {
    logic        w;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] sdat;
    int          ws;
    logic        err;
    logic [7:0]  psel;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  axi_apb_bridge_mslv dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // APB slave model: ready after cfg_ws wait states, error flag and per-slave read data
  assign pready = (penable && !cfg_stuck && acc_cyc >= cfg_ws) ? psel : 8'h00;
  assign pslverr = cfg_err ? psel : 8'h00;
  always_comb begin
    prdata = '0;
    for (int i = 0; i < 8; i++) prdata[i*32 +: 32] = sdata[i];
  end
  // counts wait states of the current ACCESS phase
  always @(posedge clk) acc_cyc <= (penable && pready == 8'h00) ? acc_cyc + 1 : 0;
  // counts APB write SETUP phases
  always @(posedge clk) if (|psel && !penable && pwrite) nwr <= nwr + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic rdy);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("awready", awready, rdy);
    chk("wready", wready, rdy);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] a, input logic rdy);
    araddr = a; arvalid = 1'b1;
    #1;
    chk("arready", arready, rdy);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", ntest);
    $fatal(1);
  end

  initial begin
    vec_t v [8];
    int base, lat, nb, acc;
    logic got;
    for (int i = 0; i < 8; i++) sdata[i] = 32'hA5A5_0000 | i;
    v[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1'b0, 8'h02, 2'b00, 32'h0, 3};
    v[1] = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h1234_5678, 2, 1'b0, 8'h08, 2'b00, 32'h1234_5678, 5};
    v[2] = '{1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'h0, 0, 1'b0, 8'h00, 2'b11, 32'h0, 2};
    v[3] = '{1'b1, 32'h0000_7FFC, 32'h0000_00AB, 4'h1, 32'h0, 1, 1'b1, 8'h80, 2'b10, 32'h0, 4};
    v[4] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1'b1, 8'h01, 2'b10, 32'hCAFE_F00D, 3};
    v[5] = '{1'b1, 32'h0000_8000, 32'h1111_1111, 4'hF, 32'h0, 0, 1'b0, 8'h00, 2'b11, 32'h0, 2};
    v[6] = '{1'b0, 32'h0001_5000, 32'h0, 4'h0, 32'h55AA_33CC, 3, 1'b0, 8'h20, 2'b00, 32'h55AA_33CC, 6};
    v[7] = '{1'b1, 32'h0000_F004, 32'h2222_2222, 4'h3, 32'h0, 0, 1'b0, 8'h00, 2'b11, 32'h0, 2};

    reset = 1'b1; bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 32'h1000; araddr = 32'h1000; wdata = 32'h0; wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid, penable, pwrite}, 0);
    chk("rst_psel", psel, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; reset = 1'b0;

    awaddr = 32'h2000; wdata = 32'h600D_F00D; wstrb = 4'hF; araddr = 32'h4000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("arb_accept", {awready, arready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    chk("arb_read_first", {psel, pwrite}, {8'h10, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("arb_rvalid", {rvalid, rresp}, {1'b1, 2'b00});
    cfg_err = 1'b1;
    @(posedge clk); #1;
    chk("arb_write_next", {psel, pwrite}, {8'h04, 1'b1});
    chk("arb_pwdata", pwdata, 32'h600D_F00D);
    repeat (2) @(posedge clk);
    #1;
    chk("arb_bslverr", {bvalid, bresp}, {1'b1, 2'b10});
    cfg_err = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      cfg_ws = v[i].ws; cfg_err = v[i].err;
      if (!v[i].w && !v[i].addr[15]) sdata[v[i].addr[14:12]] = v[i].sdat;
      if (v[i].w) send_w(v[i].addr, v[i].wdata, v[i].strb, 1'b1);
      else send_r(v[i].addr, 1'b1);
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          chk("vec_psel", psel, v[i].psel);
          chk("vec_setup_penable", penable, 0);
          if (v[i].psel != 0) begin
            chk("vec_paddr", paddr, v[i].addr);
            chk("vec_pwrite", pwrite, v[i].w);
            chk("vec_pstrb", pstrb, v[i].w ? v[i].strb : 4'h0);
            if (v[i].w) chk("vec_pwdata", pwdata, v[i].wdata);
          end
        end
        if (c == 2) chk("vec_access_penable", penable, |v[i].psel);
        if (v[i].w ? bvalid : rvalid) begin
          got = 1'b1; lat = c;
          chk("vec_resp", v[i].w ? bresp : rresp, v[i].resp);
          if (!v[i].w) chk("vec_rdata", rdata, v[i].rdata);
        end
      end
      chk("vec_latency", lat, v[i].lat);
      @(posedge clk); #1;
      chk("vec_valid_clear", {bvalid, rvalid}, 0);
    end
    cfg_ws = 0; cfg_err = 1'b0;

    bready = 1'b0; base = nwr;
    send_w(32'h0000_1000, 32'h0, 4'hF, 1'b1);
    for (int c = 0; c < 10 && !bvalid; c++) begin @(posedge clk); #1; end
    chk("bp_first_bvalid", bvalid, 1);
    for (int k = 0; k < 5; k++) send_w(32'h0000_1004 + 4 * k, k, 4'hF, k < 4);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_apb_writes", nwr - base, 1);
    sdata[3] = 32'h0F0F_1234;
    send_r(32'h0000_3000, 1'b1);
    for (int c = 0; c < 10 && !rvalid; c++) begin @(posedge clk); #1; end
    chk("bp_read_passes", {rvalid, rresp}, {1'b1, 2'b00});
    chk("bp_read_data", rdata, 32'h0F0F_1234);
    bready = 1'b1; nb = 0;
    for (int c = 0; c < 40 && nb < 5; c++) begin
      if (bvalid) nb++;
      @(posedge clk); #1;
    end
    chk("bp_drained", nb, 5);
    chk("bp_total_writes", nwr - base, 5);

    cfg_stuck = 1'b1;
    send_r(32'h0000_3000, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_holds", {psel, penable, rvalid}, {8'h08, 1'b1, 1'b0});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_apb", {psel, penable}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cfg_stuck = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", {psel, rvalid, bvalid}, 0);
    end

`ifdef APB_TIMEOUT_EN
    do_reset();
    cfg_stuck = 1'b1; acc = 0;
    send_r(32'h0000_3000, 1'b1);
    for (int c = 0; c < 400 && !rvalid; c++) begin
      @(posedge clk); #1;
      if (penable) acc++;
    end
    chk("to_access_cycles", acc, 256);
    chk("to_rresp", {rvalid, rresp}, {1'b1, 2'b10});
    chk("to_rdata", rdata, 0);
    chk("to_apb_dropped", {psel, penable}, 0);
    cfg_stuck = 1'b0;
`else
    acc = 0;
`endif
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
